// File: rtl/ifu_fetch_if.sv
// Instruction fetch bus bundle: the memory request/response channel, the
// decode-side instruction handshake, the execute redirect and the retire count.
interface ifu_fetch_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fetch_count;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready, redirect_valid, redirect_pc,
    output fetch_count
  );

  // Memory / decode / execute side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready, redirect_valid, redirect_pc,
    input  fetch_count
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding word request to instruction memory,
// a one-entry buffer toward decode, and redirect-driven flushing of stale fetches.
module ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req_valid;
  logic            r_inst_valid;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [XLEN-1:0] r_fetch_count;

  logic            w_req_fire;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_req_fire    = r_req_valid & bus.imem_req_ready;
  assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = r_inst_valid;
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = r_inst_pc;
  assign bus.fetch_count    = r_fetch_count;

  // Fetch FSM; every output is a register written alongside the state change.
  // NOTE: non-blocking assignments keep every register reading pre-edge values,
  // so the order of statements inside a branch does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      // NOTE: request valid is a register (not decoded from r_state) so it
      // stays low through reset and rises on the first edge after release.
      r_req_valid   <= 1'b0;
      r_inst_valid  <= 1'b0;
      r_inst        <= '0;
      r_inst_pc     <= '0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (w_req_fire) begin
              r_state     <= S_FLUSH;
              r_req_valid <= 1'b0;
            end else begin
              r_req_valid <= 1'b1;
            end
          end else if (w_req_fire) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end else begin
            r_req_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (bus.imem_resp_valid) begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state <= S_FLUSH;
            end
          end else if (bus.imem_resp_valid) begin
            r_state      <= S_HOLD;
            r_inst       <= bus.imem_resp_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.inst_ready) begin
            r_fetch_count <= r_fetch_count + XLEN'(1);
          end
          if (bus.redirect_valid) begin
            r_pc         <= w_redirect_pc;
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end else if (bus.inst_ready) begin
            r_pc         <= r_pc + XLEN'(4);
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end

        S_FLUSH: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
          if (bus.imem_resp_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: a latency-programmable memory model feeds responses,
// a scoreboard queue holds the instructions decode should see, directed
// scenarios exercise stalls, redirects, PC wrap and asynchronous reset.
module tb_ifu_fetch;

  localparam int              XLEN     = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
  } exp_t;

  logic clk;
  logic rst;

  ifu_fetch_if #(.XLEN(XLEN)) bus ();

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t            exp_q[$];
  logic [XLEN-1:0] seen_addr[$];
  int              accept_cnt = 0;

  // Memory model state.
  int              mem_lat   = 1;
  bit              pend      = 0;
  bit              pend_stale = 0;
  int              pend_cnt  = 0;
  logic [XLEN-1:0] pend_addr = '0;
  logic [31:0]     pend_data = '0;
  bit              ovr_en    = 0;
  logic [31:0]     ovr_data  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory: one response per accepted request, mem_lat cycles later. A response
  // is expected at decode only if no redirect touched its request.
  always @(negedge clk) begin
    bus.imem_resp_valid = 1'b0;
    if (pend) begin
      if (bus.redirect_valid) pend_stale = 1'b1;
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = pend_data;
        if (!pend_stale) exp_q.push_back('{pc: pend_addr, data: pend_data});
        pend = 1'b0;
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      seen_addr.push_back(bus.imem_req_addr);
      pend       = 1'b1;
      pend_cnt   = mem_lat;
      pend_addr  = bus.imem_req_addr;
      pend_data  = ovr_en ? ovr_data : (bus.imem_req_addr[31:0] ^ 32'h1357_9BDF);
      pend_stale = bus.redirect_valid;
    end
  end

  // Decode side: every accepted instruction is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      accept_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("inst", 64'(bus.inst), 64'(e.data));
        check("inst_pc", bus.inst_pc, e.pc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_req(input string tag, input logic [XLEN-1:0] addr);
    int n = 0;
    while (seen_addr.size() == 0 && n < 50) begin
      cyc(1);
      n++;
    end
    if (seen_addr.size() == 0) check({tag, "_timeout"}, 64'(seen_addr.size()), 64'd1);
    else check(tag, seen_addr.pop_front(), addr);
  endtask

  task automatic wait_inst_valid(input string tag);
    int n = 0;
    while (!bus.inst_valid && n < 50) begin
      cyc(1);
      n++;
    end
    if (!bus.inst_valid) check({tag, "_timeout"}, 64'(bus.inst_valid), 64'd1);
  endtask

  task automatic wait_accepts(input string tag, input int target);
    int n = 0;
    while (accept_cnt < target && n < 100) begin
      cyc(1);
      n++;
    end
    if (accept_cnt < target) check({tag, "_timeout"}, 64'(accept_cnt), 64'(target));
  endtask

  // Park the fetch unit in REQ with nothing outstanding.
  task automatic drain();
    bus.imem_req_ready = 1'b0;
    bus.inst_ready     = 1'b1;
    cyc(6);
    seen_addr.delete();
  endtask

  initial begin
    int fc;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state.
    cyc(3);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_req_addr", bus.imem_req_addr, RESET_PC);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst", 64'(bus.inst), 64'd0);
    check("rst_inst_pc", bus.inst_pc, 64'd0);
    check("rst_fetch_count", bus.fetch_count, 64'd0);
    rst = 1'b0;
    #4;
    check("req_valid_before_edge", 64'(bus.imem_req_valid), 64'd0);
    cyc(0);

    // Streaming with a one-cycle memory.
    expect_req("s1_addr0", 64'h8000_0000);
    expect_req("s1_addr1", 64'h8000_0004);
    expect_req("s1_addr2", 64'h8000_0008);
    wait_accepts("s1_accepts", 3);
    bus.imem_req_ready = 1'b0;
    check("s1_fetch_count", bus.fetch_count, 64'd3);

    // Decode stall in HOLD.
    bus.inst_ready     = 1'b0;
    ovr_en             = 1'b1;
    ovr_data           = 32'h0000_0513;
    bus.imem_req_ready = 1'b1;
    expect_req("s2_addr", 64'h8000_000C);
    wait_inst_valid("s2_hold");
    for (int i = 0; i < 5; i++) begin
      check("s2_inst_valid", 64'(bus.inst_valid), 64'd1);
      check("s2_inst", 64'(bus.inst), 64'h0000_0513);
      check("s2_inst_pc", bus.inst_pc, 64'h8000_000C);
      check("s2_no_req", 64'(bus.imem_req_valid), 64'd0);
      cyc(1);
    end
    check("s2_no_new_req", 64'(seen_addr.size()), 64'd0);
    bus.inst_ready     = 1'b1;
    bus.imem_req_ready = 1'b0;
    ovr_en             = 1'b0;
    cyc(1);
    check("s2_fetch_count", bus.fetch_count, 64'd4);
    check("s2_inst_valid_drop", 64'(bus.inst_valid), 64'd0);
    check("s2_next_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("s2_next_addr", bus.imem_req_addr, 64'h8000_0010);

    // Redirect during WAIT; the stale response lands three cycles later.
    mem_lat            = 4;
    bus.imem_req_ready = 1'b1;
    cyc(1);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0102;
    cyc(1);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s3_flush_req_valid", 64'(bus.imem_req_valid), 64'd0);
      check("s3_flush_inst_valid", 64'(bus.inst_valid), 64'd0);
      cyc(1);
    end
    check("s3_inst_valid_after", 64'(bus.inst_valid), 64'd0);
    check("s3_req_valid_after", 64'(bus.imem_req_valid), 64'd1);
    check("s3_req_addr_after", bus.imem_req_addr, 64'h8000_0100);
    mem_lat            = 1;
    bus.imem_req_ready = 1'b1;
    expect_req("s3_old_addr", 64'h8000_0010);
    expect_req("s3_new_addr", 64'h8000_0100);
    drain();

    // Redirect in HOLD together with the decode handshake.
    bus.inst_ready     = 1'b0;
    bus.imem_req_ready = 1'b1;
    wait_inst_valid("s4_hold");
    fc                 = accept_cnt;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0000_0000_0000_2003;
    cyc(1);
    bus.redirect_valid = 1'b0;
    check("s4_inst_valid_low", 64'(bus.inst_valid), 64'd0);
    check("s4_fetch_count", bus.fetch_count, 64'(fc + 1));
    check("s4_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("s4_req_addr", bus.imem_req_addr, 64'h0000_0000_0000_2000);
    seen_addr.delete();
    expect_req("s4_target_fetch", 64'h0000_0000_0000_2000);
    drain();

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(1);
    bus.redirect_valid = 1'b0;
    check("s5_req_addr_top", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    expect_req("s5_top_fetch", 64'hFFFF_FFFF_FFFF_FFFC);
    expect_req("s5_wrap_fetch", 64'h0);
    drain();

    // Asynchronous reset while a request is outstanding.
    mem_lat            = 4;
    bus.imem_req_ready = 1'b1;
    cyc(1);
    bus.imem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_fetch_count", bus.fetch_count, 64'd0);
    check("s6_async_inst", 64'(bus.inst), 64'd0);
    check("s6_async_inst_pc", bus.inst_pc, 64'd0);
    check("s6_async_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("s6_async_req_addr", bus.imem_req_addr, RESET_PC);
    pend_stale = 1'b1;
    exp_q.delete();
    seen_addr.delete();
    accept_cnt = 0;
    cyc(1);
    rst = 1'b0;
    check("s6_req_valid_released", 64'(bus.imem_req_valid), 64'd0);
    cyc(1);
    check("s6_req_valid_up", 64'(bus.imem_req_valid), 64'd1);
    check("s6_req_addr_up", bus.imem_req_addr, RESET_PC);
    cyc(2);
    check("s6_late_resp_ignored_valid", 64'(bus.inst_valid), 64'd0);
    check("s6_late_resp_ignored_req", 64'(bus.imem_req_valid), 64'd1);
    mem_lat            = 1;
    bus.imem_req_ready = 1'b1;
    expect_req("s6_first_fetch", RESET_PC);
    wait_accepts("s6_accept", 1);
    check("s6_fetch_count", bus.fetch_count, 64'd1);
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit; the producer end of the 32-bit instruction word consumed by the decode stage. It holds the PC, issues one word request at a time to instruction memory over a valid/ready request channel, and captures the response. It presents the instruction plus its PC to decode with a valid/ready handshake. Jump/branch redirects from execute flush any in-flight fetch.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, address/PC width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  XLEN  fetch address (word aligned)
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  response word valid (one per accepted request, >=1 cycle later)
imem_resp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available to decode
inst  output  32  instruction word to decode
inst_pc  output  XLEN  PC of inst
inst_ready  input  1  decode accepts inst this cycle
redirect_valid  input  1  jump/branch taken, restart fetch
redirect_pc  input  XLEN  target PC; bits [1:0] ignored, forced to 00
fetch_count  output  XLEN  number of instructions accepted by decode

Behaviour:
- Reset (async assert, sync deassert is the system's job): pc=RESET_PC, state=REQ, inst=0, inst_pc=0, inst_valid=0, imem_req_valid=0 until the first clock edge after reset release, fetch_count=0.
- States: REQ, WAIT, HOLD, FLUSH. Single outstanding request max.
- REQ: imem_req_valid=1, imem_req_addr=pc. On req_valid&&req_ready -> WAIT.
- WAIT: req_valid=0. On resp_valid: inst<=resp_data, inst_pc<=pc, -> HOLD.
- HOLD: inst_valid=1; inst/inst_pc stable while !inst_ready. On inst_ready: pc<=pc+4 (mod 2^XLEN, wraps to 0), fetch_count+=1, -> REQ. Min latency: request accepted cycle N, response N+1 -> inst_valid N+2.
- FLUSH: req_valid=0, inst_valid=0; wait for stale response, discard it, -> REQ.
- Redirect (highest priority; pc<={redirect_pc[XLEN-1:2],2'b00}):
  - REQ, request not accepted same cycle -> stay REQ with new pc.
  - REQ, request accepted same cycle -> FLUSH.
  - WAIT, no resp_valid -> FLUSH; WAIT with resp_valid same cycle -> response dropped, -> REQ.
  - FLUSH -> pc updated, stay FLUSH; if resp_valid same cycle -> REQ.
  - HOLD -> buffer dropped, inst_valid=0 next cycle, -> REQ. If inst_ready same cycle, handshake counts (fetch_count+=1) but next pc is redirect target, not pc+4.
- resp_valid in REQ or HOLD is a protocol violation: ignored, no state change.
- inst_valid is registered (no combinational path from imem_resp_* to inst_*); imem_req_valid/addr depend only on state and pc.
- fetch_count wraps at 2^XLEN.

Test Plan:
- Reset with RESET_PC default, req_ready=1, 1-cycle memory, inst_ready=1 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc matches; fetch_count=3 after 3 accepts.
- inst_ready held 0 for 5 cycles in HOLD with resp 0x0000_0513 -> inst_valid=1 and inst=0x0000_0513 stable, no new request until accept; pc then +4.
- redirect_pc=0x8000_0102 asserted in WAIT, stale response arrives 3 cycles later -> response not presented, next request addr=0x8000_0100.
- redirect in HOLD coincident with inst_ready -> fetch_count+1, next imem_req_addr=redirect target, inst_valid low the following cycle.
- pc=0xFFFF_FFFF_FFFF_FFFC fetched and accepted -> next imem_req_addr=0x0.
- rst asserted mid-WAIT (async, between edges) -> outputs reset immediately; after release first request addr=RESET_PC, late response from old request in REQ ignored.
